// File: rtl/stm32_audio_tx_pkg.sv
// Shared types and the ADC-to-link sample conversion for the STM32 audio link.
package stm32_link_pkg;

  localparam int unsigned LINK_SAMPLE_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } tx_state_t;

  // Mono mix (L+R)/2, keep the top 12 bits, flip the MSB into offset binary.
  // Bit 31 of the halved sum is bit 32 of the raw sum, so no shift is needed.
  function automatic logic [LINK_SAMPLE_W-1:0] to_link_sample(input logic [31:0] l,
                                                             input logic [31:0] r);
    logic [32:0] sum;
    sum = {l[31], l} + {r[31], r};
    return {~sum[32], sum[31:21]};
  endfunction

endpackage

// File: rtl/stm32_audio_tx_if.sv
// Parallel FPGA-to-STM32 sample bus: 12-bit data, WR strobe, asynchronous ACK.
interface stm32_audio_tx_if;
  import stm32_link_pkg::*;

  logic [LINK_SAMPLE_W-1:0] AUDIO_OUT;
  logic                     AUDIO_OUT_WR;
  logic                     AUDIO_OUT_ACK;

  modport master (output AUDIO_OUT, output AUDIO_OUT_WR, input AUDIO_OUT_ACK);
  modport slave  (input AUDIO_OUT, input AUDIO_OUT_WR, output AUDIO_OUT_ACK);
endinterface

// File: rtl/stm32_audio_tx_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
module audio_sample_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/stm32_audio_tx.sv
// FPGA-to-STM32 audio transmitter: mono mix, FIFO, four-phase WR/ACK handshake.
// Optional STROBE ACK timeout enabled by `define STM32_TX_TIMEOUT_EN.
module stm32_audio_tx
  import stm32_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT  = 1023
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        audio_in_available,
  input  logic [31:0]                 left_channel_audio_in,
  input  logic [31:0]                 right_channel_audio_in,
  output logic                        read_audio_in,
  input  logic                        tx_enable,
  stm32_audio_tx_if.master            link,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        timeout
);
  tx_state_t                r_state;
  tx_state_t                w_state_nxt;
  logic [LINK_SAMPLE_W-1:0] w_sample;
  logic [LINK_SAMPLE_W-1:0] w_fifo_data;
  logic [LINK_SAMPLE_W-1:0] r_audio_out;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_flush;
  logic                     w_full;
  logic                     w_empty;
  logic                     r_ack_meta;
  logic                     r_ack_s;
  logic                     r_tx_en_d;
  logic                     w_tx_rise;
  logic                     r_overflow;
  logic [3:0]               r_setup_cnt;
  logic                     w_tmo_exp;

  assign read_audio_in  = audio_in_available;
  assign w_push         = audio_in_available & tx_enable;
  assign w_sample       = to_link_sample(left_channel_audio_in, right_channel_audio_in);
  assign w_tx_rise      = tx_enable & ~r_tx_en_d;
  assign link.AUDIO_OUT = r_audio_out;
  assign overflow       = r_overflow;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINK_SAMPLE_W)
  ) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_sample),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_tx_en_d  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ack_meta <= link.AUDIO_OUT_ACK;
      r_ack_s    <= r_ack_meta;
      r_tx_en_d  <= tx_enable;
      r_overflow <= (r_overflow & ~w_tx_rise) | (w_push & w_full & ~w_pop);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_audio_out <= '0;
    end else if (w_pop) begin
      r_audio_out <= w_fifo_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || r_state != SETUP) begin
      r_setup_cnt <= '0;
    end else begin
      r_setup_cnt <= r_setup_cnt + 4'd1;
    end
  end

`ifdef STM32_TX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  assign w_tmo_exp = (r_tmo_cnt == TW'(ACK_TIMEOUT - 1));
  assign timeout   = r_timeout;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= (r_state == STROBE) ? r_tmo_cnt + TW'(1) : '0;
      r_timeout <= (r_timeout & ~w_tx_rise) |
                   ((r_state == STROBE) & ~r_ack_s & w_tmo_exp);
    end
  end
`else
  assign w_tmo_exp = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (tx_enable && !w_empty) w_state_nxt = SETUP;
      SETUP:   if (r_setup_cnt == 4'(SETUP_CYCLES - 1)) w_state_nxt = STROBE;
      STROBE:  if (r_ack_s) w_state_nxt = HOLD;
               else if (w_tmo_exp) w_state_nxt = IDLE;
      HOLD:    if (!r_ack_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flush is deferred to IDLE so a tx_enable drop never truncates a handshake.
  always_comb begin
    w_pop             = 1'b0;
    w_flush           = 1'b0;
    link.AUDIO_OUT_WR = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pop   = tx_enable & ~w_empty;
        w_flush = ~tx_enable;
      end
      STROBE:  link.AUDIO_OUT_WR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stm32_audio_tx.sv
// Directed + randomized bench for stm32_audio_tx with an STM32 responder model.
module tb_stm32_audio_tx;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SETUP = 2;
  localparam int unsigned TMO   = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        avail;
  logic [31:0] lch, rch;
  logic        rd;
  logic        tx_en;
  logic [4:0]  level;
  logic        ovf, tmo;

  stm32_audio_tx_if link ();

  stm32_audio_tx #(
    .FIFO_DEPTH   (DEPTH),
    .SETUP_CYCLES (SETUP),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .CLOCK_50               (clk),
    .reset_n                (rst_n),
    .audio_in_available     (avail),
    .left_channel_audio_in  (lch),
    .right_channel_audio_in (rch),
    .read_audio_in          (rd),
    .tx_enable              (tx_en),
    .link                   (link.master),
    .fifo_level             (level),
    .overflow               (ovf),
    .timeout                (tmo)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int push_cyc, rise_cyc, fall_cyc;
  int n_rises = 0, n_falls = 0;
  bit ack_on = 0;
  int ack_dly = 3;
  logic [11:0] got[$];
  logic [11:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference conversion: floor((L+R)/2), bits 31:20, offset binary.
  function automatic logic [11:0] ref_conv(input logic [31:0] l, input logic [31:0] r);
    longint s;
    s = longint'($signed(l)) + longint'($signed(r));
    s = s >>> 1;
    return 12'(((s >> 20) & 64'hFFF) ^ 64'h800);
  endfunction

  // STM32 model: ACK after ack_dly WR-high cycles, drop ACK as soon as WR falls.
  initial begin
    bit prev_wr;
    int wcnt;
    prev_wr = 0;
    wcnt = 0;
    link.AUDIO_OUT_ACK = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (link.AUDIO_OUT_WR === 1'b1) begin
        if (!prev_wr) begin rise_cyc = cyc; n_rises++; wcnt = 0; end
        wcnt++;
        if (ack_on && !link.AUDIO_OUT_ACK && wcnt >= ack_dly) begin
          link.AUDIO_OUT_ACK = 1'b1;
          got.push_back(link.AUDIO_OUT);
        end
      end else begin
        if (prev_wr) begin fall_cyc = cyc; n_falls++; end
        link.AUDIO_OUT_ACK = 1'b0;
      end
      prev_wr = (link.AUDIO_OUT_WR === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_sample(input logic [31:0] l, input logic [31:0] r, input bit track);
    @(negedge clk);
    avail = 1'b1; lch = l; rch = r;
    @(posedge clk); #1;
    avail = 1'b0;
    push_cyc = cyc;
    if (track) exp_q.push_back(ref_conv(l, r));
  endtask

  task automatic push_rand(input bit track);
    push_sample($urandom, $urandom, track);
  endtask

  task automatic wait_got(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin tick(1); k++; end
    check(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_wr(input string tag, input logic v);
    int k = 0;
    while (link.AUDIO_OUT_WR !== v && k < 100) begin tick(1); k++; end
    check(tag, 32'(link.AUDIO_OUT_WR), 32'(v));
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int f, k, hi;
    logic [31:0] nl, nr;
    rst_n = 1'b0; avail = 1'b0; lch = '0; rch = '0; tx_en = 1'b1;
    tick(3);
    avail = 1'b1; #1;
    check("rd_follow_in_reset_hi", 32'(rd), 32'd1);
    avail = 1'b0; #1;
    check("rd_follow_in_reset_lo", 32'(rd), 32'd0);
    check("rst_audio_out", 32'(link.AUDIO_OUT), 32'h0);
    check("rst_wr", 32'(link.AUDIO_OUT_WR), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);

    // First sample: L=R=0, STM32 ACKs after 3 cycles
    @(negedge clk); rst_n = 1'b1;
    ack_on = 1; ack_dly = 3;
    push_sample(32'h0, 32'h0, 1);
    check("level_after_push", 32'(level), 32'd1);
    wait_got("first_delivered", 1, 50);
    check("wr_latency", 32'(rise_cyc - push_cyc), 32'(1 + SETUP));
    cmp_stream("first");
    tick(10);

    // Conversion: directed corners plus random pairs
    push_sample(32'h7FF00000, 32'h7FF00000, 1);
    push_sample(32'h80000000, 32'h80000000, 1);
    push_sample(32'h10000000, 32'hF0000000, 1);
    check("conv_ref_max", 32'(exp_q[0]), 32'hFFF);
    check("conv_ref_min", 32'(exp_q[1]), 32'h000);
    check("conv_ref_mid", 32'(exp_q[2]), 32'h800);
    ack_dly = 1;
    for (int i = 0; i < 8; i++) push_rand(1);
    wait_got("conv_delivered", 11, 300);
    cmp_stream("conv");
    tick(10);

    // Overflow: one sample stuck in STROBE, then 17 pushes
    ack_on = 0;
    push_rand(1);
    wait_wr("ovf_stuck_wr", 1'b1);
    for (int i = 0; i < 16; i++) push_rand(1);
    check("ovf_level_full", 32'(level), 32'd16);
    check("ovf_not_yet", 32'(ovf), 32'd0);
    push_rand(0);
    check("ovf_level_still_full", 32'(level), 32'd16);
    check("ovf_set", 32'(ovf), 32'd1);
    ack_dly = $urandom_range(1, 4);
    ack_on = 1;
    wait_got("ovf_delivered", 17, 400);
    tick(10);
    cmp_stream("ovf");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // tx_enable drop during STROBE with 5 queued
    ack_on = 0;
    push_rand(1);
    for (int i = 0; i < 5; i++) push_rand(0);
    wait_wr("drop_wr", 1'b1);
    check("drop_level_5", 32'(level), 32'd5);
    @(negedge clk); tx_en = 1'b0;
    ack_on = 1;
    wait_got("drop_delivered", 1, 50);
    tick(10);
    check("drop_flushed", 32'(level), 32'd0);
    check("drop_wr_low", 32'(link.AUDIO_OUT_WR), 32'd0);
    check("drop_ovf_kept", 32'(ovf), 32'd1);
    cmp_stream("drop");
    @(negedge clk); tx_en = 1'b1;
    tick(1);
    check("rise_clears_ovf", 32'(ovf), 32'd0);
    check("rise_clears_tmo", 32'(tmo), 32'd0);
    tick(3);

    // Full FIFO with push landing on the pop edge
    ack_on = 0;
    push_rand(1);
    wait_wr("pp_stuck_wr", 1'b1);
    for (int i = 0; i < 16; i++) push_rand(1);
    check("pp_level_full", 32'(level), 32'd16);
    k = n_falls;
    ack_on = 1;
    f = 0;
    while (n_falls == k && f < 50) begin tick(1); f++; end
    check("pp_wr_fell", 32'(n_falls > k), 32'd1);
    f = fall_cyc;
    k = 0;
    while (cyc < f + 3 && k < 50) begin tick(1); k++; end
    nl = $urandom; nr = $urandom;
    push_sample(nl, nr, 1);
    check("pp_level_kept", 32'(level), 32'd16);
    check("pp_no_ovf", 32'(ovf), 32'd0);
    wait_got("pp_delivered", 18, 400);
    tick(10);
    check("pp_last_out", 32'(got[got.size()-1]), 32'(ref_conv(nl, nr)));
    cmp_stream("pp");

    // Unacknowledged sample
    ack_on = 0;
    push_rand(0);
    push_rand(1);
    k = n_falls;
    wait_wr("tmo_wr_high", 1'b1);
`ifdef STM32_TX_TIMEOUT_EN
    f = 0;
    while (n_falls == k && f < TMO + 100) begin tick(1); f++; end
    check("tmo_wr_fell", 32'(n_falls > k), 32'd1);
    check("tmo_strobe_len", 32'(fall_cyc - rise_cyc), 32'(TMO));
    check("tmo_flag", 32'(tmo), 32'd1);
`else
    exp_q.push_front(link.AUDIO_OUT);
    hi = 0;
    repeat (5000) begin
      tick(1);
      if (link.AUDIO_OUT_WR === 1'b1) hi++;
    end
    check("wait_forever_wr", 32'(hi), 32'd5000);
    check("no_tmo_flag", 32'(tmo), 32'd0);
`endif
    ack_on = 1;
    wait_got("tmo_next_delivered", exp_q.size(), 100);
    tick(10);
    cmp_stream("tmo");

    // Reset mid-handshake
    ack_on = 0;
    push_rand(0); push_rand(0); push_rand(0);
    wait_wr("rst_mid_wr", 1'b1);
    @(negedge clk); rst_n = 1'b0; avail = 1'b1;
    tick(1);
    check("rst_mid_wr_drop", 32'(link.AUDIO_OUT_WR), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_audio_out", 32'(link.AUDIO_OUT), 32'h0);
    tick(2);
    check("rst_no_push", 32'(level), 32'd0);
    check("rst_rd_follow", 32'(rd), 32'd1);
    avail = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
